lcd_timing_gen: RTL and testbench

Generates raster timing for the 800x480 RGB LCD panel from the 33 MHz pixel clock. It sits directly downstream of the pixel PLL and consumes the PLL's `outclk_0` as its clock and `locked` as a run qualifier. It outputs hsync, vsync, data-enable and pixel coordinates. It also outputs a one-cycle-early pixel request that the frame-buffer read path uses to prefetch pixel data.

---
 rtl/lcd_timing_gen.sv | 188 ++++++++++++++++++
 tb/tb_lcd_timing_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_gen.sv
// Raster timing generator for an RGB LCD panel: hsync/vsync/de/coordinates plus a one-clock-early pixel request.
// Latency: outputs registered one clock behind the h/v counters; RUN begins 2 + LOCK_CYCLES clocks after a steady lock.
// Backpressure: none; free-running once qualified, and forced idle within 3 clocks of losing PLL lock.
module lcd_timing_gen #(
    parameter int H_ACTIVE        = 800,
    parameter int H_FP            = 210,
    parameter int H_SYNC          = 20,
    parameter int H_BP            = 26,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 22,
    parameter int V_SYNC          = 10,
    parameter int V_BP            = 13,
    parameter int LOCK_CYCLES     = 1024,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pll_locked,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [10:0] pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_req,
    output logic        frame_start,
    output logic        line_start,
    output logic        running
);

    localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam int          QW     = $clog2(LOCK_CYCLES + 1);
    // The WAIT_LOCK->QUALIFY clock is the first qualifying clock, so QUALIFY exits one count early.
    localparam logic [QW-1:0] Q_EXIT = QW'(LOCK_CYCLES - 2);
    localparam logic          SYNC_IDLE = SYNC_ACTIVE_LOW;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        QUALIFY   = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            sync_q;
    logic            locked_s;
    logic [QW-1:0]   qcnt;
    logic [10:0]     h_cnt;
    logic [9:0]      v_cnt;
    logic [10:0]     h_nxt;
    logic [9:0]      v_nxt;
    logic            run_ok;

    logic            de_d;
    logic            pix_req_d;
    logic            hsync_d;
    logic            vsync_d;
    logic            frame_start_d;
    logic            line_start_d;
    logic            running_d;
    logic [10:0]     pix_x_d;
    logic [9:0]      pix_y_d;

    function automatic logic visible(input logic [10:0] h, input logic [9:0] v);
        return (h < H_VIS) && (v < V_VIS);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_q   <= pll_locked;
            locked_s <= sync_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_LOCK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = (LOCK_CYCLES <= 1) ? RUN : QUALIFY;
                end
            end
            QUALIFY: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (qcnt == Q_EXIT) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            qcnt <= '0;
        end else if (state_q == QUALIFY && state_d == QUALIFY) begin
            qcnt <= qcnt + 1'b1;
        end else begin
            qcnt <= '0;
        end
    end

    // Counters only advance while staying in RUN, so every entry to RUN starts at (0,0).
    assign run_ok = (state_q == RUN) && locked_s;

    always_comb begin
        h_nxt = '0;
        v_nxt = '0;
        if (run_ok) begin
            h_nxt = (h_cnt == H_LAST) ? 11'd0 : h_cnt + 11'd1;
            v_nxt = v_cnt;
            if (h_cnt == H_LAST) begin
                v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    // pix_req predicts next clock's de; sync_q stands in for next clock's locked_s.
    always_comb begin
        de_d          = run_ok && visible(h_cnt, v_cnt);
        pix_req_d     = (state_d == RUN) && sync_q && visible(h_nxt, v_nxt);
        hsync_d       = SYNC_IDLE ^ (run_ok && h_cnt >= HS_BEG && h_cnt < HS_END);
        vsync_d       = SYNC_IDLE ^ (run_ok && v_cnt >= VS_BEG && v_cnt < VS_END);
        frame_start_d = de_d && (h_cnt == 11'd0) && (v_cnt == 10'd0);
        line_start_d  = de_d && (h_cnt == 11'd0);
        running_d     = (state_d == RUN);
        pix_x_d       = de_d ? h_cnt : 11'd0;
        pix_y_d       = de_d ? v_cnt : 10'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            de          <= 1'b0;
            pix_req     <= 1'b0;
            hsync       <= SYNC_IDLE;
            vsync       <= SYNC_IDLE;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            running     <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
        end else begin
            de          <= de_d;
            pix_req     <= pix_req_d;
            hsync       <= hsync_d;
            vsync       <= vsync_d;
            frame_start <= frame_start_d;
            line_start  <= line_start_d;
            running     <= running_d;
            pix_x       <= pix_x_d;
            pix_y       <= pix_y_d;
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen on a reduced 32x20 raster (16x12 visible) with LOCK_CYCLES=16.
module tb_lcd_timing_gen;

    localparam int HA = 16, HF = 6, HS = 4, HB = 6, HT = HA + HF + HS + HB;
    localparam int VA = 12, VF = 3, VS = 2, VB = 3, VT = VA + VF + VS + VB;
    localparam int LC = 16;
    localparam logic [27:0] IDLE_OUTS = {7'b000_0011, 11'd0, 10'd0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pll_locked = 1'b0;
    logic        hsync, vsync, de, pix_req, frame_start, line_start, running;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic [27:0] outs;

    int   vectors = 0;
    int   miscompares = 0;
    logic prev_req = 1'b0;
    bit   inv_on = 1'b0;

    lcd_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .LOCK_CYCLES(LC)
    ) dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked),
        .hsync(hsync), .vsync(vsync), .de(de),
        .pix_x(pix_x), .pix_y(pix_y), .pix_req(pix_req),
        .frame_start(frame_start), .line_start(line_start), .running(running)
    );

    assign outs = {running, de, pix_req, frame_start, line_start, hsync, vsync, pix_x, pix_y};

    always #15 clk = ~clk;

    // Advance one clock and sample; per-clock invariants are checked here on every sample.
    task automatic tick();
        @(posedge clk);
        #1;
        if (inv_on && !rst) begin
            vectors++;
            if (de !== prev_req) begin
                miscompares++;
                $display("FAIL pix_req_lead: de=%b but previous pix_req=%b", de, prev_req);
            end
        end
        if (de === 1'b0) begin
            vectors++;
            if (pix_x !== 11'd0 || pix_y !== 10'd0) begin
                miscompares++;
                $display("FAIL coord_hold: de=0 with pix_x=%0d pix_y=%0d, need 0/0", pix_x, pix_y);
            end
        end
        prev_req = pix_req;
        inv_on = 1'b1;
    endtask

    // Starting with pll_locked just raised: running on the 18th clock, pixel (0,0) on the 19th.
    task automatic test_lock_seq(input string tag);
        for (int k = 1; k <= 19; k++) begin
            tick();
            vectors++;
            if (k <= 17 && (running !== 1'b0 || de !== 1'b0)) begin
                miscompares++;
                $display("FAIL %s_early clk%0d: running=%b de=%b, need 0/0", tag, k, running, de);
            end else if (k == 18 && {running, pix_req, de, frame_start} !== 4'b1100) begin
                miscompares++;
                $display("FAIL %s_run clk18: running,pix_req,de,fs=%b, need 1100", tag,
                         {running, pix_req, de, frame_start});
            end else if (k == 19 && {de, frame_start, line_start, running, pix_x, pix_y} !== {4'b1111, 21'd0}) begin
                miscompares++;
                $display("FAIL %s_first_pixel clk19: de,fs,ls,run=%b x=%0d y=%0d, need 1111 x=0 y=0", tag,
                         {de, frame_start, line_start, running}, pix_x, pix_y);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pll_locked = 1'b0;
        repeat (3) tick();
        vectors++;
        if (outs !== IDLE_OUTS) begin
            miscompares++;
            $display("FAIL reset_idle: outs=%h, need %h", outs, IDLE_OUTS);
        end
        pll_locked = 1'b1;
        repeat (4) tick();
        vectors++;
        if (outs !== IDLE_OUTS) begin
            miscompares++;
            $display("FAIL reset_locked_idle: outs=%h, need %h", outs, IDLE_OUTS);
        end
    endtask

    task automatic test_lock_latency();
        rst = 1'b0;
        test_lock_seq("lock");
    endtask

    task automatic test_full_frame();
        int de_n = 0, ls_n = 0, fs_n = 0, hs_pulses = 0, hs_low = 0, vs_low = 0, vs_first = -1;
        logic hs_prev = 1'b1, vs_prev = 1'b1;
        for (int n = 0; n < HT * VT + 8 && frame_start !== 1'b1; n++) tick();
        vectors++;
        if (frame_start !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_wait: frame_start=%b after timeout, need 1", frame_start);
        end
        for (int i = 0; i < HT * VT; i++) begin
            int h, v;
            logic vis;
            logic [26:0] exp_v;
            h = i % HT;
            v = i / HT;
            vis = (h < HA) && (v < VA);
            exp_v = {vis, vis ? 11'(h) : 11'd0, vis ? 10'(v) : 10'd0,
                     !(h >= HA + HF && h < HA + HF + HS), !(v >= VA + VF && v < VA + VF + VS),
                     vis && h == 0 && v == 0, vis && h == 0};
            vectors++;
            if ({de, pix_x, pix_y, hsync, vsync, frame_start, line_start} !== exp_v) begin
                miscompares++;
                $display("FAIL frame_clk %0d (h=%0d v=%0d): de=%b x=%0d y=%0d hs=%b vs=%b fs=%b ls=%b, need %h",
                         i, h, v, de, pix_x, pix_y, hsync, vsync, frame_start, line_start, exp_v);
            end
            de_n += de;
            ls_n += line_start;
            fs_n += frame_start;
            hs_low += !hsync;
            vs_low += !vsync;
            if (hs_prev && !hsync) hs_pulses++;
            if (vs_prev && !vsync && vs_first < 0) vs_first = i;
            hs_prev = hsync;
            vs_prev = vsync;
            tick();
        end
        vectors++;
        if (de_n != HA * VA || ls_n != VA || fs_n != 1) begin
            miscompares++;
            $display("FAIL frame_counts: de=%0d ls=%0d fs=%0d, need %0d/%0d/1", de_n, ls_n, fs_n, HA * VA, VA);
        end
        vectors++;
        if (hs_pulses != VT || hs_low != VT * HS) begin
            miscompares++;
            $display("FAIL hsync_pulses: pulses=%0d low_clks=%0d, need %0d/%0d", hs_pulses, hs_low, VT, VT * HS);
        end
        vectors++;
        if (vs_low != VS * HT || vs_first != (VA + VF) * HT) begin
            miscompares++;
            $display("FAIL vsync_pulse: low_clks=%0d start=%0d, need %0d/%0d", vs_low, vs_first, VS * HT, (VA + VF) * HT);
        end
        vectors++;
        if ({frame_start, de, pix_x, pix_y} !== {2'b11, 21'd0}) begin
            miscompares++;
            $display("FAIL next_frame: fs=%b de=%b x=%0d y=%0d, need 1 1 0 0", frame_start, de, pix_x, pix_y);
        end
    endtask

    task automatic test_qualify_glitch();
        rst = 1'b1;
        pll_locked = 1'b0;
        tick();
        rst = 1'b0;
        repeat (2) tick();
        pll_locked = 1'b1;
        repeat (13) tick();
        pll_locked = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            vectors++;
            if (running !== 1'b0) begin
                miscompares++;
                $display("FAIL qual_glitch_run clk%0d: running=%b, need 0", k, running);
            end
        end
        pll_locked = 1'b1;
        test_lock_seq("requal");
    endtask

    task automatic test_lock_drop();
        for (int n = 0; n < HT * VT + 8 && !(de === 1'b1 && pix_x == 11'd8 && pix_y == 10'd5); n++) tick();
        vectors++;
        if (!(de === 1'b1 && pix_x == 11'd8 && pix_y == 10'd5)) begin
            miscompares++;
            $display("FAIL drop_wait: de=%b x=%0d y=%0d, need 1 8 5", de, pix_x, pix_y);
        end
        pll_locked = 1'b0;
        repeat (3) tick();
        for (int k = 3; k < 8; k++) begin
            vectors++;
            if (outs !== IDLE_OUTS) begin
                miscompares++;
                $display("FAIL drop_idle clk%0d: outs=%h, need %h", k, outs, IDLE_OUTS);
            end
            tick();
        end
        pll_locked = 1'b1;
        test_lock_seq("relock");
    endtask

    task automatic test_rst_in_run();
        repeat (50) tick();
        vectors++;
        if (running !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre_run: running=%b, need 1", running);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (outs !== IDLE_OUTS) begin
            miscompares++;
            $display("FAIL rst_in_run_idle: outs=%h, need %h", outs, IDLE_OUTS);
        end
        tick();
        rst = 1'b0;
        test_lock_seq("rerun");
    endtask

    initial begin
        test_reset();
        test_lock_latency();
        test_full_frame();
        test_qualify_glitch();
        test_lock_drop();
        test_rst_in_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
